// File: rtl/led_pattern_arbiter.sv
// led_pattern_arbiter: round-robin owner of the 6-LED bank.
// Each grant shows one latched pattern for dur display ticks.
module led_pattern_arbiter #(
    parameter int unsigned WAIT_TIME    = 13_500_000,
    parameter logic [5:0]  IDLE_PATTERN = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [17:0] pat,
    input  logic [23:0] dur,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [5:0]  led
);

    localparam logic [23:0] TICK_AT = 24'(WAIT_TIME - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  owner;
    logic [23:0] presc;
    logic [7:0]  remaining;

    logic [1:0]  win;
    logic [5:0]  win_pat;
    logic [7:0]  win_dur;
    logic [2:0]  win_oh;
    logic        tick;

    assign tick = (presc == TICK_AT);

    // first set request searching ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        win = ptr;
        for (int i = 2; i >= 0; i--) begin
            logic [2:0] s;
            logic [1:0] idx;
            s   = {1'b0, ptr} + 3'(i);
            idx = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
            if (req[idx]) win = idx;
        end
    end

    // slice the winner's pattern and duration
    always_comb begin
        win_pat = pat[5:0];
        win_dur = dur[7:0];
        win_oh  = 3'b001;
        unique case (win)
            2'd1: begin
                win_pat = pat[11:6];
                win_dur = dur[15:8];
                win_oh  = 3'b010;
            end
            2'd2: begin
                win_pat = pat[17:12];
                win_dur = dur[23:16];
                win_oh  = 3'b100;
            end
            default: ;
        endcase
    end

    // ownership FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            presc     <= 24'd0;
            remaining <= 8'd0;
            gnt       <= 3'b000;
            done      <= 3'b000;
            led       <= IDLE_PATTERN;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 3'b000;
                    if (|req) begin
                        state     <= SHOW;
                        owner     <= win;
                        gnt       <= win_oh;
                        led       <= win_pat;
                        presc     <= 24'd0;
                        remaining <= (win_dur == 8'd0) ? 8'd1 : win_dur;
                    end
                end
                SHOW: begin
                    presc <= tick ? 24'd0 : presc + 24'd1;
                    if (!req[owner]) begin
                        // abort beats a coinciding final tick
                        state <= RELEASE;
                        gnt   <= 3'b000;
                        led   <= IDLE_PATTERN;
                        presc <= 24'd0;
                    end else if (tick) begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= RELEASE;
                            gnt   <= 3'b000;
                            led   <= IDLE_PATTERN;
                            done  <= gnt;
                            presc <= 24'd0;
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    done  <= 3'b000;
                    ptr   <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                    done  <= 3'b000;
                    led   <= IDLE_PATTERN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// tb_led_pattern_arbiter: directed checks of grant order,
// display length, done pulses, abort and asynchronous reset.
module tb_led_pattern_arbiter;

    localparam logic [5:0] IDL = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [17:0] pat;
    logic [23:0] dur;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [5:0]  led;

    int vectors = 0;
    int miscompares = 0;

    led_pattern_arbiter #(
        .WAIT_TIME   (4),
        .IDLE_PATTERN(IDL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .pat  (pat),
        .dur  (dur),
        .gnt  (gnt),
        .done (done),
        .led  (led)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] l_exp,
                       input logic [2:0] g_exp, input logic [2:0] d_exp);
        vectors++;
        assert ({led, gnt, done} === {l_exp, g_exp, d_exp}) else begin
            miscompares++;
            $error("FAIL %s: observed led=%b gnt=%b done=%b expected led=%b gnt=%b done=%b",
                   tag, led, gnt, done, l_exp, g_exp, d_exp);
        end
    endtask

    // linear directed sequence
    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        pat   = 18'd0;
        dur   = 24'd0;
        #12;
        chk("reset_state", IDL, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_no_req", IDL, 3'b000, 3'b000);
        end

        // single grant, requester 0, dur 3
        pat = {6'b000000, 6'b000000, 6'b010101};
        dur = {8'd0, 8'd0, 8'd3};
        req = 3'b001;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("single_show", 6'b010101, 3'b001, 3'b000);
        end
        step();
        chk("single_done", IDL, 3'b000, 3'b001);
        req = 3'b000;
        step();
        chk("single_idle", IDL, 3'b000, 3'b000);

        // dur 0 on requester 2 shows for one tick
        pat = {6'b001100, 6'b000000, 6'b000000};
        dur = 24'd0;
        req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dur0_show", 6'b001100, 3'b100, 3'b000);
        end
        step();
        chk("dur0_done", IDL, 3'b000, 3'b100);
        req = 3'b000;
        step();
        chk("dur0_idle", IDL, 3'b000, 3'b000);

        // round robin with all requests held
        pat = {6'b100100, 6'b010010, 6'b001001};
        dur = {8'd1, 8'd1, 8'd1};
        req = 3'b111;
        for (int r = 0; r < 4; r++) begin
            logic [2:0] oh;
            logic [5:0] pv;
            oh = (r == 1) ? 3'b010 : (r == 2) ? 3'b100 : 3'b001;
            pv = (r == 1) ? 6'b010010 : (r == 2) ? 6'b100100 : 6'b001001;
            for (int i = 0; i < 4; i++) begin
                step();
                chk("rr_show", pv, oh, 3'b000);
            end
            step();
            chk("rr_release", IDL, 3'b000, oh);
            step();
            chk("rr_gap", IDL, 3'b000, 3'b000);
            if (r == 3) req = 3'b000;
        end
        step();
        chk("rr_stop", IDL, 3'b000, 3'b000);

        // abort requester 1 after 6 cycles of dur 5
        pat = {6'b000000, 6'b110011, 6'b000111};
        dur = {8'd1, 8'd5, 8'd1};
        req = 3'b010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_show", 6'b110011, 3'b010, 3'b000);
        end
        req = 3'b000;
        step();
        chk("abort_release", IDL, 3'b000, 3'b000);
        req = 3'b011;
        step();
        chk("abort_idle", IDL, 3'b000, 3'b000);
        step();
        chk("abort_next_r0", 6'b000111, 3'b001, 3'b000);
        req = 3'b000;
        step();
        chk("abort2_release", IDL, 3'b000, 3'b000);
        step();
        chk("abort2_idle", IDL, 3'b000, 3'b000);

        // reset in the middle of requester 0's display
        pat = {6'b000000, 6'b101010, 6'b011110};
        dur = {8'd0, 8'd1, 8'd4};
        req = 3'b001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_pre_show", 6'b011110, 3'b001, 3'b000);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", IDL, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold", IDL, 3'b000, 3'b000);
        end
        req = 3'b011;
        rst_n = 1'b1;
        step();
        chk("rst_first_r0", 6'b011110, 3'b001, 3'b000);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("rst_show_r0", 6'b011110, 3'b001, 3'b000);
        end
        step();
        chk("rst_done_r0", IDL, 3'b000, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_arbiter.md
# led_pattern_arbiter

Shares the 6-LED bank between three pattern requesters under a round-robin req/gnt handshake. Each requester owns the LEDs for a programmable number of display ticks. A tick is WAIT_TIME clock cycles from an internal prescaler. The block sits between pattern-generating logic (walkers, blinkers, status reporters) and the top-level `led[5:0]` pins. When the bank is unowned, it drives IDLE_PATTERN.

## Interface
- WAIT_TIME, 13_500_000, clock cycles per display tick; legal range 2..2^24.
- IDLE_PATTERN, 6'b111111, LED value driven when no requester owns the bank (all-ones = all LEDs off on the board).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low; all state clears immediately on assertion.
- req  in  3  request per requester; requester holds high until it sees done or chooses to abort.
- pat  in  18  patterns; pat[6i+5:6i] belongs to requester i.
- dur  in  24  display length in ticks; dur[8i+7:8i] belongs to requester i; value 0 is treated as 1.
- gnt  out  3  one-hot grant; high for the whole ownership period.
- done  out  3  one-cycle pulse to the requester whose display completed normally.
- led  out  6  registered LED drive.

## Operation
- FSM states:
  - IDLE: led = IDLE_PATTERN, gnt = 0.
  - SHOW: led = latched pattern, gnt = one-hot owner.
  - RELEASE: one cycle; gnt = 0, led = IDLE_PATTERN.
- IDLE -> SHOW when any req bit is high.
  - Winner is the first set bit searching ptr, ptr+1, ptr+2 (mod 3).
  - The same edge latches the owner index, pat slice, remaining = max(dur slice, 1), and clears the prescaler to 0.
- Prescaler (24 bits) runs only in SHOW.
  - It counts 0..WAIT_TIME-1; tick is asserted when the count equals WAIT_TIME-1, then it wraps to 0.
  - On each tick, remaining decrements by 1.
- SHOW -> RELEASE with done:
  - Condition: tick and remaining == 1.
  - RELEASE pulses done[owner].
- SHOW -> RELEASE without done (abort):
  - Condition: req[owner] low in any SHOW cycle.
  - Abort takes priority over a coinciding final tick.
- RELEASE -> IDLE always.
  - In RELEASE, ptr <= owner+1 mod 3, after both completion and abort.
- Pattern and dur inputs are ignored outside the grant edge; changes during SHOW have no effect.
- Requests from non-owners during SHOW/RELEASE are held off, never dropped by the block.
- Reset values:
  - state IDLE, ptr 0, prescaler 0, remaining 0.
  - gnt 3'b000, done 3'b000, led = IDLE_PATTERN.

## Timing
- All outputs are registered.
- req sampled high at edge k in IDLE -> gnt and led valid after edge k; latency 1 cycle.
- Display time is exactly max(dur,1)*WAIT_TIME cycles of SHOW.
  - gnt is high for exactly that many cycles on normal completion.
- Final tick at edge r -> after edge r: gnt = 0, done = 1, led = IDLE_PATTERN (RELEASE).
- After edge r+1: IDLE, done = 0.
- The next grant is visible at the earliest after edge r+2.
  - Minimum 2-cycle IDLE_PATTERN gap between owners.
- Abort: req[owner] low before edge a -> after edge a: RELEASE, gnt = 0, no done.
- rst_n low at any point, including mid-SHOW:
  - Outputs take reset values asynchronously.
  - The pending display is discarded; no done is issued.
- After rst_n deasserts, the first req is sampled at the first rising clk edge; ptr = 0, so requester 0 wins a tie.

## Test plan
Directed tests run with WAIT_TIME = 4.
- Reset, req = 0 for 20 cycles -> led = 6'b111111, gnt = 0, done = 0 throughout.
- Single grant: req = 3'b001, pat[5:0] = 6'b010101, dur[7:0] = 3.
  - gnt = 3'b001 one cycle after req, for exactly 12 cycles; led = 6'b010101.
  - Then done[0] pulses once; led returns to 6'b111111.
- Round robin: req = 3'b111 held, all dur = 1.
  - Grants in order 001, 010, 100, 001.
  - Each held 4 cycles, separated by 2 cycles of IDLE_PATTERN.
- dur = 0 for requester 2 with req = 3'b100 -> gnt = 3'b100 for exactly 4 cycles, then done = 3'b100.
- Abort: requester 1 granted with dur = 5; drop req[1] after 6 cycles.
  - gnt falls on the next edge; done never pulses; ptr advances, so req = 3'b011 next grants requester 0.
- rst_n pulsed low mid-SHOW of requester 0 (dur = 4).
  - led = 6'b111111 and gnt = 0 immediately, with no done.
  - After release with req = 3'b011, requester 0 is granted first.
